// File: rtl/stall_ctrl.sv
// ---------------------------------------------------------------------------
// stall_ctrl
//
// Hazard / stall controller for the 5-stage pipeline. Decides, in the same
// cycle, whether the instruction sitting in D may advance. It holds the PC
// and F/D registers and bubbles the D/E register when:
//   - a D-stage operand is needed before the E or M producer can supply it
//     (Tuse < Tnew on a matching, non-zero register address), or
//   - an HI/LO-dependent instruction meets a multiply/divide that is
//     starting this cycle or still counting down.
// It also owns the MD busy countdown and a saturating count of stalled
// cycles for performance monitoring.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_d_rs/_rt     D-stage source register addresses
//   i_d_rs_tuse    cycles until D needs rs (3 = never used)
//   i_d_rt_tuse    cycles until D needs rt (3 = never used)
//   i_d_is_md      D instruction touches the MD unit / HI / LO
//   i_e_wa/_tnew   E-stage destination (0 = none) and cycles to result
//   i_m_wa/_tnew   M-stage destination (0 = none) and cycles to result
//   i_e_md_start   E-stage mult/multu/div/divu this cycle
//   i_e_md_is_div  qualifies i_e_md_start: 1 = divide, 0 = multiply
//   o_pc_en        PC register write enable
//   o_fd_en        F/D register enable
//   o_de_flush     D/E register flush (bubble insert)
//   o_md_busy      MD countdown non-zero
//   o_stall_cnt    saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_d_rs,
    input  logic [4:0]       i_d_rt,
    input  logic [1:0]       i_d_rs_tuse,
    input  logic [1:0]       i_d_rt_tuse,
    input  logic             i_d_is_md,
    input  logic [4:0]       i_e_wa,
    input  logic [1:0]       i_e_tnew,
    input  logic [4:0]       i_m_wa,
    input  logic [1:0]       i_m_tnew,
    input  logic             i_e_md_start,
    input  logic             i_e_md_is_div,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_de_flush,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [MD_W-1:0]  mdCnt_q, mdCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic             stallRs, stallRt, stallMd, stall;

    // A source operand must wait when one of the in-flight producers writes
    // it and will not have the value ready by the time D consumes it. A
    // producer with tnew = 0 can never trip the compare, which is exactly the
    // forwarding case. Register 0 is hard-wired and never waits.
    function automatic logic operandStalls(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] eWa,
        input logic [1:0] eTnew,
        input logic [4:0] mWa,
        input logic [1:0] mTnew
    );
        operandStalls = (addr != 5'd0) &&
                        (((addr == eWa) && (tuse < eTnew)) ||
                         ((addr == mWa) && (tuse < mTnew)));
    endfunction

    // Hazard detection is combinational so the hold/bubble decision takes
    // effect in the very cycle the dependent instruction sits in D.
    always_comb begin
        stallRs = operandStalls(i_d_rs, i_d_rs_tuse, i_e_wa, i_e_tnew, i_m_wa, i_m_tnew);
        stallRt = operandStalls(i_d_rt, i_d_rt_tuse, i_e_wa, i_e_tnew, i_m_wa, i_m_tnew);
        stallMd = i_d_is_md && (i_e_md_start || (mdCnt_q != '0));
        stall   = stallRs || stallRt || stallMd;
    end

    // Next-state for the MD countdown and the performance counter. A new
    // start always reloads, even over a countdown still in progress. The
    // counter sticks at all-ones rather than wrapping.
    always_comb begin
        mdCnt_d    = mdCnt_q;
        stallCnt_d = stallCnt_q;
        if (i_e_md_start) begin
            mdCnt_d = i_e_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (mdCnt_q != '0) begin
            mdCnt_d = mdCnt_q - MD_W'(1);
        end
        if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mdCnt_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            mdCnt_q    <= mdCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // While reset is held the pipeline is frozen with a bubble in D/E,
    // regardless of whatever the hazard inputs happen to show.
    assign o_pc_en     = i_reset && !stall;
    assign o_fd_en     = i_reset && !stall;
    assign o_de_flush  = !i_reset || stall;
    assign o_md_busy   = i_reset && (mdCnt_q != '0);
    assign o_stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stall_ctrl
//
// Scoreboard bench for stall_ctrl. The stimulus process drives one input
// set per cycle on the falling edge and pushes the expected outputs into a
// queue; the monitor samples the DUT shortly afterwards and pops/compares.
// A second instance with a 4-bit counter shares the same inputs so counter
// saturation is observed alongside the full-width counter.
// ---------------------------------------------------------------------------
module tb_stall_ctrl;

    typedef struct {
        logic       reset;
        logic [4:0] dRs, dRt;
        logic [1:0] rsTuse, rtTuse;
        logic       isMd;
        logic [4:0] eWa, mWa;
        logic [1:0] eTnew, mTnew;
        logic       mdStart, mdIsDiv;
    } stimT;

    typedef struct {
        logic pcEn, fdEn, flush, busy;
        int   cnt;
        int   cntSat;
    } expT;

    logic        clk;
    logic        rstN;
    logic [4:0]  dRs, dRt, eWa, mWa;
    logic [1:0]  rsTuse, rtTuse, eTnew, mTnew;
    logic        isMd, mdStart, mdIsDiv;
    logic        pcEn, fdEn, flush, busy;
    logic [31:0] stallCnt;
    logic        pcEnS, fdEnS, flushS, busyS;
    logic [3:0]  stallCntS;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference state: remaining MD busy cycles and total stalled cycles.
    int  mdLeft   = 0;
    int  stallTot = 0;

    stall_ctrl dut (
        .i_clk(clk), .i_reset(rstN),
        .i_d_rs(dRs), .i_d_rt(dRt), .i_d_rs_tuse(rsTuse), .i_d_rt_tuse(rtTuse),
        .i_d_is_md(isMd), .i_e_wa(eWa), .i_e_tnew(eTnew), .i_m_wa(mWa), .i_m_tnew(mTnew),
        .i_e_md_start(mdStart), .i_e_md_is_div(mdIsDiv),
        .o_pc_en(pcEn), .o_fd_en(fdEn), .o_de_flush(flush), .o_md_busy(busy),
        .o_stall_cnt(stallCnt)
    );

    stall_ctrl #(.CNT_W(4)) dutSat (
        .i_clk(clk), .i_reset(rstN),
        .i_d_rs(dRs), .i_d_rt(dRt), .i_d_rs_tuse(rsTuse), .i_d_rt_tuse(rtTuse),
        .i_d_is_md(isMd), .i_e_wa(eWa), .i_e_tnew(eTnew), .i_m_wa(mWa), .i_m_tnew(mTnew),
        .i_e_md_start(mdStart), .i_e_md_is_div(mdIsDiv),
        .o_pc_en(pcEnS), .o_fd_en(fdEnS), .o_de_flush(flushS), .o_md_busy(busyS),
        .o_stall_cnt(stallCntS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stimT idle();
        stimT s;
        s.reset   = 1'b1;
        s.dRs     = 5'd0;  s.dRt    = 5'd0;
        s.rsTuse  = 2'd3;  s.rtTuse = 2'd3;
        s.isMd    = 1'b0;
        s.eWa     = 5'd0;  s.mWa    = 5'd0;
        s.eTnew   = 2'd0;  s.mTnew  = 2'd0;
        s.mdStart = 1'b0;  s.mdIsDiv = 1'b0;
        return s;
    endfunction

    // How many more cycles an operand must wait for one producer; zero means
    // the value is there (or forwardable) by the time it is needed.
    function automatic int waitFor(input int addr, input int tuse, input int wa, input int tnew);
        if (addr == 0 || addr != wa) return 0;
        return (tnew > tuse) ? (tnew - tuse) : 0;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show, then advance
    // the reference state across the coming rising edge.
    task automatic applyStimulus(input stimT s);
        expT e;
        int  waitCycles;
        logic mustStall;
        @(negedge clk);
        rstN = s.reset;
        dRs = s.dRs; dRt = s.dRt; rsTuse = s.rsTuse; rtTuse = s.rtTuse;
        isMd = s.isMd; eWa = s.eWa; mWa = s.mWa; eTnew = s.eTnew; mTnew = s.mTnew;
        mdStart = s.mdStart; mdIsDiv = s.mdIsDiv;

        if (!s.reset) begin
            mdLeft   = 0;
            stallTot = 0;
            e.pcEn = 1'b0; e.fdEn = 1'b0; e.flush = 1'b1; e.busy = 1'b0;
            e.cnt = 0; e.cntSat = 0;
            expQ.push_back(e);
            return;
        end

        waitCycles = 0;
        waitCycles += waitFor(s.dRs, s.rsTuse, s.eWa, s.eTnew);
        waitCycles += waitFor(s.dRs, s.rsTuse, s.mWa, s.mTnew);
        waitCycles += waitFor(s.dRt, s.rtTuse, s.eWa, s.eTnew);
        waitCycles += waitFor(s.dRt, s.rtTuse, s.mWa, s.mTnew);
        mustStall = (waitCycles > 0) || (s.isMd && (s.mdStart || mdLeft > 0));

        e.pcEn   = !mustStall;
        e.fdEn   = !mustStall;
        e.flush  = mustStall;
        e.busy   = (mdLeft > 0);
        e.cnt    = stallTot;
        e.cntSat = (stallTot > 15) ? 15 : stallTot;
        expQ.push_back(e);

        if (mustStall) stallTot++;
        if (s.mdStart) mdLeft = s.mdIsDiv ? 10 : 5;
        else if (mdLeft > 0) mdLeft--;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Monitor: samples a little after each falling edge, once inputs have
    // settled, and compares against the oldest pending expectation.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc_en",        int'(pcEn),      int'(e.pcEn));
                checkOutput("fd_en",        int'(fdEn),      int'(e.fdEn));
                checkOutput("de_flush",     int'(flush),     int'(e.flush));
                checkOutput("md_busy",      int'(busy),      int'(e.busy));
                checkOutput("stall_cnt",    int'(stallCnt),  e.cnt);
                checkOutput("stall_cnt_w4", int'(stallCntS), e.cntSat);
                checkOutput("sat_pc_en",    int'(pcEnS),     int'(e.pcEn));
                checkOutput("sat_md_busy",  int'(busyS),     int'(e.busy));
            end
        end
    end

    initial begin
        stimT s;
        int   guard;
        rstN = 1'b0;
        dRs = '0; dRt = '0; rsTuse = 2'd3; rtTuse = 2'd3; isMd = 1'b0;
        eWa = '0; mWa = '0; eTnew = '0; mTnew = '0; mdStart = 1'b0; mdIsDiv = 1'b0;

        // Reset, then load-use through E, then through M, then forwarded.
        s = idle(); s.reset = 1'b0; applyStimulus(s);
        s = idle(); s.dRs = 5'd8; s.rsTuse = 2'd0; s.eWa = 5'd8; s.eTnew = 2'd2; applyStimulus(s);
        s.eWa = 5'd0; s.mWa = 5'd8; s.mTnew = 2'd1; applyStimulus(s);
        s.mTnew = 2'd0; applyStimulus(s);

        // Register 0 and an unused operand never stall.
        s = idle(); s.eTnew = 2'd2; applyStimulus(s);
        s = idle(); s.dRt = 5'd9; s.rtTuse = 2'd3; s.eWa = 5'd9; s.eTnew = 2'd2; applyStimulus(s);

        // Multiply busy with an MD-dependent instruction waiting in D.
        s = idle(); s.reset = 1'b0; applyStimulus(s);
        s = idle(); s.isMd = 1'b1; s.mdStart = 1'b1; applyStimulus(s);
        s.mdStart = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(s);

        // Divide busy with no MD user in D.
        s = idle(); s.mdStart = 1'b1; s.mdIsDiv = 1'b1; applyStimulus(s);
        s = idle();
        for (int i = 0; i < 11; i++) applyStimulus(s);

        // Reset dropped partway through a divide, then released.
        s = idle(); s.mdStart = 1'b1; s.mdIsDiv = 1'b1; s.isMd = 1'b1; applyStimulus(s);
        s.mdStart = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.reset = 1'b0; applyStimulus(s);
        s = idle(); applyStimulus(s); applyStimulus(s);

        // Long hazard to push the narrow counter into saturation.
        s = idle(); s.dRt = 5'd3; s.rtTuse = 2'd0; s.mWa = 5'd3; s.mTnew = 2'd2;
        for (int i = 0; i < 20; i++) applyStimulus(s);

        // Randomized traffic; small register range makes matches frequent.
        for (int i = 0; i < 500; i++) begin
            s = idle();
            s.reset   = ($urandom_range(0, 59) != 0);
            s.dRs     = 5'($urandom_range(0, 3));
            s.dRt     = 5'($urandom_range(0, 3));
            s.rsTuse  = 2'($urandom_range(0, 3));
            s.rtTuse  = 2'($urandom_range(0, 3));
            s.isMd    = ($urandom_range(0, 2) == 0);
            s.eWa     = 5'($urandom_range(0, 3));
            s.mWa     = 5'($urandom_range(0, 3));
            s.eTnew   = 2'($urandom_range(0, 2));
            s.mTnew   = 2'($urandom_range(0, 1));
            s.mdStart = ($urandom_range(0, 9) == 0);
            s.mdIsDiv = 1'($urandom_range(0, 1));
            applyStimulus(s);
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Hazard/stall controller for the 5-stage pipeline. It produces the enable and flush controls consumed by the PC register, the F/D pipeline register and the D/E pipeline register.
- It compares D-stage operand Tuse against E/M-stage Tnew to detect load-use and similar data hazards.
- It owns the multiply/divide busy countdown, so HI/LO-dependent instructions stall while the MD unit works.
- It keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu.
- CNT_W, 32, width of the stall performance counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_d_rs  input  5  D-stage rs register address.
- i_d_rt  input  5  D-stage rt register address.
- i_d_rs_tuse  input  2  cycles until D instr needs rs (3 = never used).
- i_d_rt_tuse  input  2  cycles until D instr needs rt (3 = never used).
- i_d_is_md  input  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- i_e_wa  input  5  E-stage destination register (0 = none).
- i_e_tnew  input  2  cycles until E result is available.
- i_m_wa  input  5  M-stage destination register (0 = none).
- i_m_tnew  input  2  cycles until M result is available.
- i_e_md_start  input  1  E-stage instr is mult/multu/div/divu this cycle.
- i_e_md_is_div  input  1  qualifies i_e_md_start: 1 = div, 0 = mult.
- o_pc_en  output  1  PC register write enable.
- o_fd_en  output  1  F/D register enable (drives its i_en).
- o_de_flush  output  1  D/E register flush (inserts bubble).
- o_md_busy  output  1  MD countdown non-zero.
- o_stall_cnt  output  CNT_W  total stalled cycles since reset.

Behaviour:

Reset
- i_reset low clears md_cnt and o_stall_cnt to 0 immediately, independent of the clock.
- While i_reset is low, the outputs are forced to o_pc_en=0, o_fd_en=0, o_de_flush=1, o_md_busy=0.
- The first edge after release behaves normally.

Data hazard (combinational, same cycle)
- stall_rs = (i_d_rs!=0) & ((i_d_rs==i_e_wa & i_d_rs_tuse<i_e_tnew) | (i_d_rs==i_m_wa & i_d_rs_tuse<i_m_tnew)).
- stall_rt is the same expression with rt.
- Register 0 never stalls.
- An address match with tnew=0 never stalls; forwarding covers it.

MD hazard
- stall_md = i_d_is_md & (i_e_md_start | md_cnt!=0).

Control outputs
- stall = stall_rs | stall_rt | stall_md.
- o_pc_en = o_fd_en = ~stall.
- o_de_flush = stall.
- All three are purely combinational from inputs and md_cnt, with zero-cycle latency.

MD countdown
- md_cnt width is clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Rising edge with i_e_md_start=1: md_cnt loads DIV_CYCLES if i_e_md_is_div, else MULT_CYCLES. Loading takes priority over decrement, so a start while md_cnt!=0 reloads.
- Otherwise md_cnt decrements by 1 when non-zero and holds at 0.
- o_md_busy = (md_cnt!=0), registered-state derived.
- After a mult start at edge N, busy is high for exactly MULT_CYCLES cycles.

Stall counter
- o_stall_cnt increments by 1 on each rising edge where stall=1.
- It saturates at all-ones.

Reset mid-operation
- Asserting reset mid-countdown drops md_cnt to 0 and busy to 0 immediately.
- No pending stall survives reset.

Test Plan:
1. Load-use: i_d_rs=8, rs_tuse=0, i_e_wa=8, i_e_tnew=2 -> o_pc_en=0, o_fd_en=0, o_de_flush=1 that cycle. Then set i_e_wa=0, i_m_wa=8, i_m_tnew=1 -> still stalled. Then i_m_tnew=0 -> stall clears; o_stall_cnt=2.
2. $0 and no-use: i_d_rs=0, i_e_wa=0, tnew=2 -> no stall. Also rt_tuse=3, i_d_rt=i_e_wa=9, tnew=2 -> no stall.
3. Mult busy: pulse i_e_md_start=1, is_div=0 for one edge. Hold i_d_is_md=1 -> stall on the start cycle plus exactly 5 following cycles; o_md_busy high 5 cycles; o_stall_cnt=6.
4. Div busy: pulse start with is_div=1 -> o_md_busy high 10 cycles. With i_d_is_md=0, no stall at any point.
5. Async reset mid-div: after 3 busy cycles, drop i_reset between edges -> o_md_busy=0, o_stall_cnt=0, o_pc_en=0, o_de_flush=1 immediately. After release with no hazards, o_pc_en=1, o_de_flush=0.
6. Saturation: with CNT_W=4, hold a hazard 20 cycles -> o_stall_cnt stops at 15.
